// File: rtl/clic_irq_arbiter.sv
// clic_irq_arbiter: arbitrates NumSrc interrupt sources and presents one winner (one-hot, id, level) to the core.
// Optional feature: define CLIC_EDGE_TRIG_EN to honour src_edge_i (edge-triggered sources with sticky pending).
module clic_irq_arbiter #(
   parameter int NumSrc     = 256,
   parameter int LevelWidth = 8,
   localparam int IdWidth   = $clog2(NumSrc)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NumSrc-1:0]            src_irq_i,
   input  logic [NumSrc-1:0]            src_ie_i,
   input  logic [NumSrc*LevelWidth-1:0] src_level_i,
   input  logic [NumSrc-1:0]            src_edge_i,
   output logic [NumSrc-1:0]            irq_o,
   output logic [IdWidth-1:0]           irq_id_o,
   output logic [LevelWidth-1:0]        irq_level_o,
   input  logic                         irq_ack_i,
   output logic [IdWidth-1:0]           ack_id_o,
   output logic                         ack_valid_o
);

   typedef enum logic [1:0] {
      IDLE,
      PRESENT,
      ACKED
   } state_e;

   localparam logic [NumSrc-1:0] OneLsb = NumSrc'(1);

   state_e                  state_q, state_d;
   logic [NumSrc-1:0]       pending_q, pending_d;
   logic [NumSrc-1:0]       req;
   logic [NumSrc-1:0]       arb_mask;
   logic [IdWidth-1:0]      id_q, id_d;
   logic [LevelWidth-1:0]   level_q, level_d;
   logic [IdWidth-1:0]      ack_id_q, ack_id_d;
   logic                    ack_accept;
   logic                    retract;
   logic                    win_found;
   logic [IdWidth-1:0]      win_id;
   logic [LevelWidth-1:0]   win_level;

   assign ack_accept = (state_q == PRESENT) && irq_ack_i;
   assign arb_mask   = (state_q == ACKED) ? (OneLsb << ack_id_q) : '0;

`ifdef CLIC_EDGE_TRIG_EN
   logic [NumSrc-1:0] prev_q;
   logic [NumSrc-1:0] ack_clr;

   assign ack_clr = ack_accept ? (OneLsb << id_q) : '0;

   // Edge sources latch a rising edge and hold until their own ack; a new edge wins over a same-cycle ack.
   always_comb begin
      pending_d = pending_q;
      for (int i = 0; i < NumSrc; i++) begin
         if (src_edge_i[i]) begin
            pending_d[i] = (src_irq_i[i] & ~prev_q[i]) | (pending_q[i] & ~ack_clr[i]);
         end else begin
            pending_d[i] = src_irq_i[i] & src_ie_i[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q <= '0;
      end else begin
         prev_q <= src_irq_i;
      end
   end

   assign req     = pending_q & src_ie_i & ~arb_mask;
   assign retract = !pending_q[id_q] && !src_edge_i[id_q];
`else
   logic unused_edge;

   assign unused_edge = ^src_edge_i;
   assign pending_d   = src_irq_i & src_ie_i;
   assign req         = pending_q & ~arb_mask;
   assign retract     = !pending_q[id_q];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   // Highest level wins, strict compare keeps the lowest index on ties.
   // The presented source competes with its latched level so later level edits cannot self-preempt.
   always_comb begin
      logic [LevelWidth-1:0] lvl;
      win_found = 1'b0;
      win_id    = '0;
      win_level = '0;
      for (int i = 0; i < NumSrc; i++) begin
         lvl = src_level_i[i*LevelWidth +: LevelWidth];
         if ((state_q == PRESENT) && (IdWidth'(i) == id_q)) begin
            lvl = level_q;
         end
         if (req[i] && (!win_found || (lvl > win_level))) begin
            win_found = 1'b1;
            win_id    = IdWidth'(i);
            win_level = lvl;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         id_q     <= '0;
         level_q  <= '0;
         ack_id_q <= '0;
      end else begin
         state_q  <= state_d;
         id_q     <= id_d;
         level_q  <= level_d;
         ack_id_q <= ack_id_d;
      end
   end

   // Ack beats retract, retract beats preempt; only a strictly higher level preempts.
   always_comb begin
      state_d  = state_q;
      id_d     = id_q;
      level_d  = level_q;
      ack_id_d = ack_id_q;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               id_d    = win_id;
               level_d = win_level;
               state_d = PRESENT;
            end
         end
         PRESENT: begin
            if (ack_accept) begin
               ack_id_d = id_q;
               state_d  = ACKED;
            end else if (retract) begin
               state_d = IDLE;
            end else if (win_found && (win_level > level_q)) begin
               id_d    = win_id;
               level_d = win_level;
            end
         end
         ACKED: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign irq_o       = (state_q == PRESENT) ? (OneLsb << id_q) : '0;
   assign irq_id_o    = id_q;
   assign irq_level_o = level_q;
   assign ack_id_o    = ack_id_q;
   assign ack_valid_o = (state_q == ACKED);

`ifndef SYNTHESIS
   a_irq_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(irq_o));
`endif

endmodule

// File: tb/tb_clic_irq_arbiter.sv
// tb_clic_irq_arbiter: directed scoreboard bench for clic_irq_arbiter (level mode; edge cases when CLIC_EDGE_TRIG_EN is defined).
module tb_clic_irq_arbiter;

   localparam int NumSrc = 256;
   localparam int Lw     = 8;
   localparam int EvPres = 0;
   localparam int EvDrop = 1;
   localparam int EvAck  = 2;

   typedef struct {
      int kind;
      int id;
      int level;
      int cyc;
   } ev_t;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic [NumSrc-1:0]      src_irq = '0;
   logic [NumSrc-1:0]      src_ie = '0;
   logic [NumSrc*Lw-1:0]   src_level = '0;
   logic [NumSrc-1:0]      src_edge = '0;
   logic                   irq_ack = 1'b0;
   logic [NumSrc-1:0]      irq_o;
   logic [7:0]             irq_id_o;
   logic [Lw-1:0]          irq_level_o;
   logic [7:0]             ack_id_o;
   logic                   ack_valid_o;

   int  cyc = 0;
   int  checks = 0;
   int  errors = 0;
   ev_t expq[$];
   logic [NumSrc-1:0] prev_irq = '0;

   clic_irq_arbiter #(.NumSrc(NumSrc), .LevelWidth(Lw)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .src_irq_i  (src_irq),
      .src_ie_i   (src_ie),
      .src_level_i(src_level),
      .src_edge_i (src_edge),
      .irq_o      (irq_o),
      .irq_id_o   (irq_id_o),
      .irq_level_o(irq_level_o),
      .irq_ack_i  (irq_ack),
      .ack_id_o   (ack_id_o),
      .ack_valid_o(ack_valid_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input int idx, input bit irq, input bit ie, input int lvl);
      src_irq[idx]          = irq;
      src_ie[idx]           = ie;
      src_level[idx*Lw +: Lw] = lvl[Lw-1:0];
   endtask

   task automatic pulseAck();
      irq_ack = 1'b1;
      tick(1);
      irq_ack = 1'b0;
   endtask

   task automatic expectEv(input int kind, input int id, input int lvl, input int at);
      ev_t e;
      e.kind  = kind;
      e.id    = id;
      e.level = lvl;
      e.cyc   = at;
      expq.push_back(e);
   endtask

   task automatic checkVal(input string name, input logic [NumSrc-1:0] act, input logic [NumSrc-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s got=%0h required=%0h", name, act, req);
      end
   endtask

   // Pops the next expected event and compares it with what the DUT just presented.
   task automatic checkOutput(input int kind, input int id, input int lvl, input logic [NumSrc-1:0] irq);
      ev_t e;
      logic [NumSrc-1:0] exp_irq;
      bit ok;
      checks++;
      if (expq.size() == 0) begin
         errors++;
         $display("[TB] FAIL unexpected_event got kind=%0d id=%0d lvl=%0h cyc=%0d required none", kind, id, lvl, cyc);
      end else begin
         e = expq.pop_front();
         exp_irq = '0;
         ok = (e.kind == kind) && (e.cyc == cyc);
         if (e.kind == EvPres) begin
            exp_irq[e.id] = 1'b1;
            ok = ok && (id == e.id) && (lvl == e.level) && (irq === exp_irq);
         end else if (e.kind == EvAck) begin
            ok = ok && (id == e.id) && (irq === '0);
         end
         if (!ok) begin
            errors++;
            $display("[TB] FAIL event got kind=%0d id=%0d lvl=%0h cyc=%0d required kind=%0d id=%0d lvl=%0h cyc=%0d",
                     kind, id, lvl, cyc, e.kind, e.id, e.level, e.cyc);
         end
      end
   endtask

   // Monitor: any change of irq_o or an ack pulse is an observable event.
   always @(negedge clk) begin
      if (rst_n) begin
         checks++;
         if (!$onehot0(irq_o)) begin
            errors++;
            $display("[TB] FAIL onehot0 got=%0h required at most one bit", irq_o);
         end
         if (ack_valid_o) begin
            checkOutput(EvAck, int'(ack_id_o), 0, irq_o);
         end else if (irq_o !== prev_irq) begin
            if (irq_o == '0) checkOutput(EvDrop, 0, 0, irq_o);
            else checkOutput(EvPres, int'(irq_id_o), int'(irq_level_o), irq_o);
         end
         prev_irq = irq_o;
      end else begin
         prev_irq = '0;
      end
   end

   initial begin
      int c;
      $display("[TB] start");
      tick(2);
      checkVal("reset_irq", irq_o, '0);
      checkVal("reset_id", NumSrc'(irq_id_o), '0);
      checkVal("reset_level", NumSrc'(irq_level_o), '0);
      checkVal("reset_ack_valid", NumSrc'(ack_valid_o), '0);
      checkVal("reset_ack_id", NumSrc'(ack_id_o), '0);
      rst_n = 1'b1;
      tick(2);

      // basic present and ack
      c = cyc; applyStimulus(5, 1, 1, 'h40); expectEv(EvPres, 5, 'h40, c + 2);
      tick(4);
      c = cyc; applyStimulus(5, 0, 1, 'h40); expectEv(EvAck, 5, 0, c + 1);
      pulseAck(); tick(4);

      // equal-level tie, lowest index first, then the other after ack
      c = cyc; applyStimulus(3, 1, 1, 'h20); applyStimulus(7, 1, 1, 'h20); expectEv(EvPres, 3, 'h20, c + 2);
      tick(4);
      c = cyc; applyStimulus(3, 0, 1, 'h20); expectEv(EvAck, 3, 0, c + 1); expectEv(EvPres, 7, 'h20, c + 3);
      pulseAck(); tick(4);
      c = cyc; applyStimulus(7, 0, 1, 'h20); expectEv(EvDrop, 0, 0, c + 2);
      tick(4);

      // preemption by a higher level
      c = cyc; applyStimulus(2, 1, 1, 'h10); expectEv(EvPres, 2, 'h10, c + 2);
      tick(4);
      c = cyc; applyStimulus(9, 1, 1, 'h80); expectEv(EvPres, 9, 'h80, c + 2);
      tick(4);
      c = cyc; applyStimulus(2, 0, 1, 'h10); applyStimulus(9, 0, 1, 'h80); expectEv(EvDrop, 0, 0, c + 2);
      tick(4);

      // retract before ack
      c = cyc; applyStimulus(4, 1, 1, 'h30); expectEv(EvPres, 4, 'h30, c + 2);
      tick(4);
      c = cyc; applyStimulus(4, 0, 1, 'h30); expectEv(EvDrop, 0, 0, c + 2);
      tick(4);

      // ack in the same cycle a higher level would preempt
      c = cyc; applyStimulus(6, 1, 1, 'h20); expectEv(EvPres, 6, 'h20, c + 2);
      tick(3); applyStimulus(8, 1, 1, 'h90); tick(1);
      c = cyc; applyStimulus(6, 0, 1, 'h20); expectEv(EvAck, 6, 0, c + 1); expectEv(EvPres, 8, 'h90, c + 3);
      pulseAck(); tick(4);
      c = cyc; applyStimulus(8, 0, 1, 'h90); expectEv(EvDrop, 0, 0, c + 2);
      tick(4);

      // ack while idle is ignored
      pulseAck(); tick(3);

      // equal-level later arrival with lower index does not preempt
      c = cyc; applyStimulus(10, 1, 1, 'h50); expectEv(EvPres, 10, 'h50, c + 2);
      tick(3); applyStimulus(1, 1, 1, 'h50); tick(4);
      c = cyc; applyStimulus(10, 0, 1, 'h50); expectEv(EvAck, 10, 0, c + 1); expectEv(EvPres, 1, 'h50, c + 3);
      pulseAck(); tick(4);
      c = cyc; applyStimulus(1, 0, 1, 'h50); expectEv(EvDrop, 0, 0, c + 2);
      tick(4);

      // disabled source is not presented until enabled
      applyStimulus(12, 1, 0, 'h7F); tick(4);
      c = cyc; applyStimulus(12, 1, 1, 'h7F); expectEv(EvPres, 12, 'h7F, c + 2);
      tick(4);
      c = cyc; applyStimulus(12, 0, 1, 'h7F); expectEv(EvDrop, 0, 0, c + 2);
      tick(4);

      // level 0 at index 0 is a real request; top index at max level preempts it
      c = cyc; applyStimulus(0, 1, 1, 0); expectEv(EvPres, 0, 0, c + 2);
      tick(4);
      c = cyc; applyStimulus(255, 1, 1, 'hFF); expectEv(EvPres, 255, 'hFF, c + 2);
      tick(4);
      c = cyc; applyStimulus(0, 0, 1, 0); applyStimulus(255, 0, 1, 'hFF); expectEv(EvDrop, 0, 0, c + 2);
      tick(4);

`ifdef CLIC_EDGE_TRIG_EN
      // edge source: one-cycle pulse stays presented; new pulse during ACKED re-presents
      src_edge[1] = 1'b1;
      c = cyc; applyStimulus(1, 1, 1, 'h33); expectEv(EvPres, 1, 'h33, c + 2);
      tick(1); applyStimulus(1, 0, 1, 'h33); tick(6);
      c = cyc; expectEv(EvAck, 1, 0, c + 1); expectEv(EvPres, 1, 'h33, c + 3);
      pulseAck(); applyStimulus(1, 1, 1, 'h33);
      tick(1); applyStimulus(1, 0, 1, 'h33); tick(4);
      c = cyc; expectEv(EvAck, 1, 0, c + 1);
      pulseAck(); tick(4);
      src_edge[1] = 1'b0;
`endif

      // asynchronous reset while presenting
      c = cyc; applyStimulus(20, 1, 1, 'h11); expectEv(EvPres, 20, 'h11, c + 2);
      tick(4);
      #2 rst_n = 1'b0;
      #1;
      checkVal("async_reset_irq", irq_o, '0);
      checkVal("async_reset_ack_valid", NumSrc'(ack_valid_o), '0);
      applyStimulus(20, 0, 1, 'h11);
      tick(2);
      rst_n = 1'b1;
      tick(6);

      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("[TB] FAIL missing_events got=%0d outstanding required=0", expq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
